multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Sequential multiply/divide controller that computes MULT/MULTU/DIV/DIVU results iteratively, one bit per cycle.
- Drives the HI/LO register pair: the hi/lo data buses and the hi_write/lo_write strobes.
- Also forwards MTHI/MTLO writes.
- Sits between the main control FSM (which stalls on busy) and the HI/LO registers.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset (0 = reset)
- start_mult  input  1  request multiply of op_a*op_b (sampled in IDLE only)
- start_div  input  1  request divide op_a/op_b (sampled in IDLE only)
- is_signed  input  1  1 = MULT/DIV two's-complement, 0 = MULTU/DIVU
- op_a  input  WIDTH  multiplicand / dividend
- op_b  input  WIDTH  multiplier / divisor
- mthi  input  1  move mt_data to HI
- mtlo  input  1  move mt_data to LO
- mt_data  input  WIDTH  data for mthi/mtlo
- hi_in  output  WIDTH  data to HI register
- lo_in  output  WIDTH  data to LO register
- hi_write  output  1  HI write strobe
- lo_write  output  1  LO write strobe
- busy  output  1  operation in progress; control FSM must stall
- done  output  1  one-cycle pulse at completion
- div_by_zero  output  1  one-cycle pulse with done when divisor was 0

Behaviour:
Reset values:
- All outputs 0, state IDLE, internal registers 0.
- Reset assertion at any time (including mid-operation) aborts the operation with no HI/LO write.

States: IDLE, MULT, DIV, FIX, WRITE.

IDLE, accept cycle (edge E0):
- start_mult has priority if start_mult and start_div are both high.
- On accept: latch |op_a| and |op_b| (absolute values only when is_signed, otherwise raw); latch sign flags; clear the iteration counter.
- Multiply goes to MULT.
- Divide with op_b != 0 goes to DIV.
- Divide with op_b == 0 goes to WRITE with the zero flag set.
- Start requests while busy are ignored.

MULT:
- Shift-add over a 2*WIDTH accumulator, WIDTH cycles.
- Then go to FIX.

DIV:
- Restoring division, WIDTH cycles.
- Quotient builds in the low half, remainder in the high half.
- Then go to FIX.

FIX, one cycle:
- Multiply, signed: negate the 2*WIDTH product if sign_a^sign_b.
- Divide, signed: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
- Arithmetic is modulo 2^WIDTH, so 0x80000000 / 0xFFFFFFFF (signed) yields quotient 0x80000000, remainder 0.

WRITE, one cycle:
- Multiply: hi_in = product[2W-1:W], lo_in = product[W-1:0].
- Divide: lo_in = quotient, hi_in = remainder.
- hi_write = lo_write = 1 and done = 1 for this cycle only.
- Divide-by-zero case: done = 1 and div_by_zero = 1, hi_write = lo_write = 0, HI/LO unchanged.

busy:
- High from the cycle after accept through WRITE inclusive.
- Multiply/divide latency: done asserts WIDTH+2 cycles after the accept edge.
- Divide by zero: done asserts 1 cycle after the accept edge.

mthi/mtlo:
- Honoured only in IDLE and not in WRITE.
- Combinational in the same cycle: hi_in/lo_in = mt_data, with the matching strobe.
- Both may be high together.
- Ignored while busy.
- mthi together with an accepted start: the mthi write occurs in that cycle, and the later WRITE overwrites it.

Outputs: hi_in/lo_in are don't-care whenever their strobe is low; the bench must check them only under the strobe.

Optional Feature:
MULTDIV_EARLY_EXIT_EN
- Defined: in MULT, when the remaining unshifted multiplier bits are all zero, jump to FIX immediately. The product is identical; latency becomes (index of the highest set bit of |op_b|)+1 iterations, and op_b = 0 goes straight to FIX after the accept edge. DIV timing is unchanged.
- Undefined: MULT always takes exactly WIDTH iterations.

Decomposition:
- Package multdiv_pkg: state enum (IDLE, MULT, DIV, FIX, WRITE), WIDTH default constant, op-kind enum (OP_MULT, OP_DIV).
- Sub-module multdiv_iter_unit: accumulator/shift registers, iteration counter, one-step add/subtract-compare. Controlled by load/step/fix strobes from the FSM in multdiv_ctrl.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 cycles: done, hi_write = lo_write = 1, hi_in = 0xFFFFFFFE, lo_in = 0x00000001; busy for 34 cycles.
- MULT signed -3*7 -> hi_in = 0xFFFFFFFF, lo_in = 0xFFFFFFEB.
- DIV signed -7/2 -> lo_in = 0xFFFFFFFD (-3), hi_in = 0xFFFFFFFF (-1). DIVU 100/7 -> lo_in = 14, hi_in = 2.
- DIV 5/0 -> 1 cycle later: done = 1, div_by_zero = 1, hi_write = lo_write = 0.
- start_mult and start_div high together with 6, 3 -> product path: lo_in = 18. start_div pulsed mid-multiply -> ignored. mthi 0xABCD while busy -> no write. mthi 0xABCD in IDLE -> hi_write same cycle, hi_in = 0xABCD.
- Reset pulled low at iteration 10 of a multiply -> busy = 0 and all strobes 0 immediately; no write afterwards. With MULTDIV_EARLY_EXIT_EN defined, MULTU 5*3 -> done 4 cycles after accept (2 iterations + FIX + WRITE).

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide controller: FSM states,
// operation kind and the default operand width.
package multdiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    DIV   = 3'd2,
    FIX   = 3'd3,
    WRITE = 3'd4
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_kind_t;

endpackage

// File: rtl/multdiv_iter_unit.sv
// Datapath for iterative multiply/divide: magnitude registers, shift-add and
// restoring-divide steps, sign fix-up. Optional MULTDIV_EARLY_EXIT_EN ends MULT early.
module multdiv_iter_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  op_kind_t           op_kind,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] result,
  output logic               mult_last,
  output logic               div_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   opb_r;
  logic [CW-1:0]      count_r;
  logic               sign_a_r;
  logic               sign_b_r;
  op_kind_t           kind_r;

  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [2*WIDTH-1:0] mult_next_s;
  logic [WIDTH:0]     rem_shift_s;
  logic [WIDTH:0]     diff_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [2*WIDTH-1:0] fix_next_s;
  logic               last_iter_s;

  // Operand magnitudes, single-step results and sign fix-up
  always_comb begin
    abs_a_s     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    abs_b_s     = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    last_iter_s = (count_r == LAST_ITER);
    mult_next_s = opb_r[0] ? (acc_r + mcand_r) : acc_r;
    // Partial remainder shifted left with the next dividend bit; W+1 bits so the borrow is visible
    rem_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    diff_s      = rem_shift_s - {1'b0, opb_r};
    if (diff_s[WIDTH]) begin
      div_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
    quot_s = (sign_a_r ^ sign_b_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s  = sign_a_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    if (kind_r == OP_MULT) begin
      fix_next_s = (sign_a_r ^ sign_b_r) ? -acc_r : acc_r;
    end else begin
      fix_next_s = {rem_s, quot_s};
    end
  end

  // Load, iterate and fix up the accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      kind_r   <= OP_MULT;
    end else if (load) begin
      acc_r    <= (op_kind == OP_MULT) ? {(2*WIDTH){1'b0}} : {{WIDTH{1'b0}}, abs_a_s};
      mcand_r  <= {{WIDTH{1'b0}}, abs_a_s};
      opb_r    <= abs_b_s;
      count_r  <= {CW{1'b0}};
      sign_a_r <= is_signed & op_a[WIDTH-1];
      sign_b_r <= is_signed & op_b[WIDTH-1];
      kind_r   <= op_kind;
    end else if (step) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
      if (kind_r == OP_MULT) begin
        acc_r   <= mult_next_s;
        mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
        opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
      end else begin
        acc_r <= div_next_s;
      end
    end else if (fix) begin
      acc_r <= fix_next_s;
    end
  end

  // Termination flags for the controller
  always_comb begin
    result   = acc_r;
    div_last = last_iter_s;
`ifdef MULTDIV_EARLY_EXIT_EN
    // Multiplier bits still to be consumed after this step are all zero
    mult_last = last_iter_s | (opb_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
    mult_last = last_iter_s;
`endif
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Multiply/divide controller driving the HI/LO register pair and forwarding MTHI/MTLO.
// Optional MULTDIV_EARLY_EXIT_EN: multiply stops once remaining multiplier bits are zero.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] hi_in,
  output logic [WIDTH-1:0] lo_in,
  output logic             hi_write,
  output logic             lo_write,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t             state_r;
  state_t             state_s;
  logic               dz_r;
  logic               dz_s;
  logic               load_s;
  logic               step_s;
  logic               fix_s;
  op_kind_t           op_kind_s;
  logic [2*WIDTH-1:0] result_s;
  logic               mult_last_s;
  logic               div_last_s;

  multdiv_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .step      (step_s),
    .fix       (fix_s),
    .op_kind   (op_kind_s),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .result    (result_s),
    .mult_last (mult_last_s),
    .div_last  (div_last_s)
  );

  // Next-state and datapath strobes
  always_comb begin
    state_s   = state_r;
    dz_s      = dz_r;
    load_s    = 1'b0;
    step_s    = 1'b0;
    fix_s     = 1'b0;
    op_kind_s = OP_MULT;
    case (state_r)
      IDLE: begin
        if (start_mult) begin
          load_s    = 1'b1;
          op_kind_s = OP_MULT;
          dz_s      = 1'b0;
`ifdef MULTDIV_EARLY_EXIT_EN
          state_s   = (op_b == {WIDTH{1'b0}}) ? FIX : MULT;
`else
          state_s   = MULT;
`endif
        end else if (start_div) begin
          load_s    = 1'b1;
          op_kind_s = OP_DIV;
          if (op_b == {WIDTH{1'b0}}) begin
            dz_s    = 1'b1;
            state_s = WRITE;
          end else begin
            dz_s    = 1'b0;
            state_s = DIV;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MULT: begin
        step_s  = 1'b1;
        state_s = mult_last_s ? FIX : MULT;
      end
      DIV: begin
        step_s  = 1'b1;
        state_s = div_last_s ? FIX : DIV;
      end
      FIX: begin
        fix_s   = 1'b1;
        state_s = WRITE;
      end
      WRITE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and divide-by-zero flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      dz_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      dz_r    <= dz_s;
    end
  end

  // HI/LO write port and status; everything is forced low while reset is held
  always_comb begin
    hi_in       = {WIDTH{1'b0}};
    lo_in       = {WIDTH{1'b0}};
    hi_write    = 1'b0;
    lo_write    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    if (reset) begin
      case (state_r)
        IDLE: begin
          if (mthi) begin
            hi_write = 1'b1;
            hi_in    = mt_data;
          end else begin
            hi_write = 1'b0;
          end
          if (mtlo) begin
            lo_write = 1'b1;
            lo_in    = mt_data;
          end else begin
            lo_write = 1'b0;
          end
        end
        MULT, DIV, FIX: begin
          busy = 1'b1;
        end
        WRITE: begin
          busy = 1'b1;
          done = 1'b1;
          if (dz_r) begin
            div_by_zero = 1'b1;
          end else begin
            hi_write = 1'b1;
            lo_write = 1'b1;
            hi_in    = result_s[2*WIDTH-1:WIDTH];
            lo_in    = result_s[WIDTH-1:0];
          end
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end else begin
      busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: directed operations push expected HI/LO events,
// a negedge monitor pops and compares every strobe/done event.
module tb_multdiv_ctrl;

`ifdef MULTDIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] mt_data = 32'h0;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        hi_write;
  logic        lo_write;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  typedef struct {
    logic        hw;
    logic        lw;
    logic        dn;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } ev_t;

  ev_t exp_q[$];
  int  pass_cnt = 0;
  int  total_cnt = 0;

  multdiv_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_mult  (start_mult),
    .start_div   (start_div),
    .is_signed   (is_signed),
    .op_a        (op_a),
    .op_b        (op_b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .mt_data     (mt_data),
    .hi_in       (hi_in),
    .lo_in       (lo_in),
    .hi_write    (hi_write),
    .lo_write    (lo_write),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic int exp_mult_lat(input logic sgn, input logic [31:0] b);
    logic [31:0] ab;
    int it;
    ab = (sgn && b[31]) ? -b : b;
    it = 0;
    for (int i = 0; i < 32; i++) if (ab[i]) it = i + 1;
    if (EARLY) return it + 2;
    else return 34;
  endfunction

  task automatic push_ev(input logic hw, input logic lw, input logic dn, input logic dz,
                         input logic [31:0] hi, input logic [31:0] lo, input string name);
    ev_t e;
    e.hw = hw; e.lw = lw; e.dn = dn; e.dz = dz; e.hi = hi; e.lo = lo; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic do_op(input string name, input logic sm, input logic sd, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input int elat, input logic disturb, input logic mt_also);
    int lat;
    int busy_cnt;
    bit seen;
    @(posedge clk); #1;
    start_mult = sm; start_div = sd; is_signed = sgn; op_a = a; op_b = b;
    if (mt_also) begin
      mthi = 1'b1;
      mt_data = 32'h0000_1234;
      push_ev(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, {name, "_mthi"});
    end
    push_ev(!edz, !edz, 1'b1, edz, ehi, elo, name);
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0; mthi = 1'b0;
    op_a = 32'hDEAD_BEEF; op_b = 32'h0;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        if (disturb) begin
          start_div = (lat == 5);
          mthi = (lat == 5);
          mt_data = 32'h0000_ABCD;
        end
      end
    end
    start_div = 1'b0; mthi = 1'b0;
    check({name, "_latency"}, lat, elat);
    check({name, "_busy_cycles"}, busy_cnt, elat);
  endtask

  // Monitor: every output event must match the head of the expected queue
  initial begin
    ev_t e;
    logic ok;
    forever begin
      @(negedge clk);
      if (hi_write || lo_write || done || div_by_zero) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: hw=%b lw=%b done=%b dz=%b hi=0x%08h lo=0x%08h",
                   hi_write, lo_write, done, div_by_zero, hi_in, lo_in);
        end else begin
          e = exp_q.pop_front();
          ok = (hi_write == e.hw) && (lo_write == e.lw) && (done == e.dn) &&
               (div_by_zero == e.dz) && (!e.hw || hi_in == e.hi) && (!e.lw || lo_in == e.lo);
          if (ok) pass_cnt++;
          else $display("FAIL %s: got hw=%b lw=%b done=%b dz=%b hi=0x%08h lo=0x%08h, expected hw=%b lw=%b done=%b dz=%b hi=0x%08h lo=0x%08h",
                        e.name, hi_write, lo_write, done, div_by_zero, hi_in, lo_in,
                        e.hw, e.lw, e.dn, e.dz, e.hi, e.lo);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    #2;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_strobes", {30'h0, hi_write, lo_write}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    do_op("multu_max", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, 1'b0, exp_mult_lat(1'b0, 32'hFFFF_FFFF), 1'b1, 1'b0);
    do_op("mult_m3x7", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007,
          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, exp_mult_lat(1'b1, 32'h7), 1'b0, 1'b0);
    do_op("div_m7d2", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b0, 1'b0);
    do_op("divu_100d7", 1'b0, 1'b1, 1'b0, 32'd100, 32'd7,
          32'd2, 32'd14, 1'b0, 34, 1'b0, 1'b0);
    do_op("div_by_zero", 1'b0, 1'b1, 1'b1, 32'd5, 32'd0,
          32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0);
    do_op("both_starts", 1'b1, 1'b1, 1'b0, 32'd6, 32'd3,
          32'h0, 32'd18, 1'b0, exp_mult_lat(1'b0, 32'd3), 1'b0, 1'b1);
    do_op("div_min_m1", 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0, 32'h8000_0000, 1'b0, 34, 1'b0, 1'b0);
    do_op("multu_5x3", 1'b1, 1'b0, 1'b0, 32'd5, 32'd3,
          32'h0, 32'd15, 1'b0, exp_mult_lat(1'b0, 32'd3), 1'b0, 1'b0);
    do_op("mult_min_min", 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, 32'h0, 1'b0, exp_mult_lat(1'b1, 32'h8000_0000), 1'b0, 1'b0);
    do_op("div_7dm2", 1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE,
          32'd1, 32'hFFFF_FFFD, 1'b0, 34, 1'b0, 1'b0);
    do_op("divu_max_d1", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1,
          32'h0, 32'hFFFF_FFFF, 1'b0, 34, 1'b0, 1'b0);
    do_op("mult_0x5", 1'b1, 1'b0, 1'b1, 32'd0, 32'd5,
          32'h0, 32'h0, 1'b0, exp_mult_lat(1'b1, 32'd5), 1'b0, 1'b0);
    do_op("multu_7x0", 1'b1, 1'b0, 1'b0, 32'd7, 32'd0,
          32'h0, 32'h0, 1'b0, exp_mult_lat(1'b0, 32'd0), 1'b0, 1'b0);

    @(posedge clk); #1;
    mthi = 1'b1; mt_data = 32'h0000_ABCD;
    push_ev(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_ABCD, 32'h0, "mthi_idle");
    @(posedge clk); #1;
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h5A5A_0001;
    push_ev(1'b1, 1'b1, 1'b0, 1'b0, 32'h5A5A_0001, 32'h5A5A_0001, "mthi_mtlo");
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b1; mt_data = 32'h0000_0077;
    push_ev(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0077, "mtlo_idle");
    @(posedge clk); #1;
    mtlo = 1'b0;

    // Abort a multiply with reset at iteration 10; nothing may be written afterwards
    start_mult = 1'b1; is_signed = 1'b0; op_a = 32'd9; op_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_abort_busy", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_strobes", {30'h0, hi_write, lo_write}, 32'h0);
    check("abort_done", {30'h0, done, div_by_zero}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_abort_busy", {31'h0, busy}, 32'h0);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("queue_drained", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
